// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg
// Shared widths, master identifiers and the burst-counter helper used by the
// data-memory arbiter (dm_arbiter) and its grant picker (dm_arb_pick).
//   ADDR_W - word address width of dm_4k (byte address bits 13:2)
//   DATA_W - memory data width
//   BE_W   - byte-enable width
//   BCNT_W - width of the master-1 burst beat counter
//   M_CPU / M_DMA - master ids as stored in the "last granted" register
package dm_arb_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int BCNT_W = 4;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    typedef logic [BCNT_W-1:0] bcnt_t;

    // Burst beat counter increment that sticks at all-ones instead of wrapping,
    // so an over-long locked burst can never look like a fresh one.
    function automatic bcnt_t bcnt_inc(input bcnt_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// dm_arb_pick
// Combinational grant decision for the two-master data-memory arbiter.
// Ports:
//   m0_req, m1_req - access requests from master 0 (CPU) and master 1 (DMA)
//   last           - id of the master granted most recently
//   lock_act       - master 1 currently holds a burst lock
//   gnt0, gnt1     - one-hot (or zero) grant for this cycle
module dm_arb_pick
    import dm_arb_pkg::*;
(
    input  logic m0_req,
    input  logic m1_req,
    input  logic last,
    input  logic lock_act,
    output logic gnt0,
    output logic gnt1
);

    // Master 1 wins when it holds the lock, when it is the only requester,
    // or on contention when master 0 was the last one served. Master 0 takes
    // whatever master 1 does not, so the two grants can never both be high.
    always_comb begin
        gnt1 = m1_req && (lock_act || !m0_req || (last == M_CPU));
        gnt0 = m0_req && !gnt1;
    end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter
// Shares the single-port dm_4k data memory between the CPU load/store path
// (master 0) and a DMA/debug loader (master 1). At most one access is granted
// per cycle; the winner's address, byte enables, write data and write strobe
// drive the memory port, and read data is registered back to the winner one
// cycle later. Contention is resolved round-robin; master 1 may lock the
// memory for up to BURST_MAX consecutive beats.
// Ports:
//   clk, rst                  - clock, asynchronous active-low reset
//   mX_req/we/be/addr/wdata   - master X request, write flag, byte enables,
//                               word address, write data
//   mX_gnt                    - master X granted this cycle (combinational)
//   mX_rvalid, mX_rdata       - registered read return for master X
//   m1_lock                   - master 1 wants to keep the grant next cycle
//   dm_addr/be/din/wr         - to dm_4k (written on the falling clock edge)
//   dm_dout                   - from dm_4k (combinational read)
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int BURST_MAX = 8,
    parameter int ADDR_W    = dm_arb_pkg::ADDR_W
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [BE_W-1:0]   m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [BE_W-1:0]   m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [BE_W-1:0]   dm_be,
    output logic [DATA_W-1:0] dm_din,
    output logic              dm_wr,
    input  logic [DATA_W-1:0] dm_dout
);

    localparam logic [BCNT_W:0] BURST_LIM = (BCNT_W+1)'(BURST_MAX);

    logic        last;
    logic        lock_act;
    bcnt_t       bcnt;
    logic        pick_gnt0;
    logic        pick_gnt1;
    logic [BCNT_W:0] bcnt_nxt;

    dm_arb_pick u_pick (
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .last     (last),
        .lock_act (lock_act),
        .gnt0     (pick_gnt0),
        .gnt1     (pick_gnt1)
    );

    // Grants are suppressed while reset is asserted so the memory port stays
    // quiet even if masters keep requesting through reset.
    assign m0_gnt = pick_gnt0 && rst;
    assign m1_gnt = pick_gnt1 && rst;

    // Beat count after this cycle, one bit wider so the comparison against
    // BURST_MAX cannot wrap.
    assign bcnt_nxt = {1'b0, bcnt} + 1'b1;

    // Memory port mux. Everything here depends only on registered state and
    // master inputs, so it is stable from posedge through the negedge write.
    always_comb begin
        dm_addr = '0;
        dm_be   = '0;
        dm_din  = '0;
        dm_wr   = 1'b0;
        if (m0_gnt) begin
            dm_addr = m0_addr;
            dm_be   = m0_be;
            dm_din  = m0_wdata;
            dm_wr   = m0_we;
        end else if (m1_gnt) begin
            dm_addr = m1_addr;
            dm_be   = m1_be;
            dm_din  = m1_wdata;
            dm_wr   = m1_we;
        end
    end

    // Arbitration state and read return. A locked master-1 beat extends the
    // burst until BURST_MAX beats have been served; any other cycle ends it.
    // Read data is captured at the posedge that closes the grant cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last      <= M_DMA;
            lock_act  <= 1'b0;
            bcnt      <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (m0_gnt) begin
                last <= M_CPU;
            end else if (m1_gnt) begin
                last <= M_DMA;
            end

            if (m1_gnt && m1_lock) begin
                bcnt     <= bcnt_inc(bcnt);
                lock_act <= (bcnt_nxt < BURST_LIM);
            end else begin
                bcnt     <= '0;
                lock_act <= 1'b0;
            end

            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) begin
                m0_rdata <= dm_dout;
            end
            if (m1_gnt && !m1_we) begin
                m1_rdata <= dm_dout;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter
// Self-checking bench for dm_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_dm_arbiter;

    localparam int BURST_MAX = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [3:0]  m0_be;
    logic [11:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid, m1_lock;
    logic [3:0]  m1_be;
    logic [11:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic [11:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_din, dm_dout;
    logic        dm_wr;

    int n_cmp = 0;
    int n_fail = 0;

    dm_arbiter #(.BURST_MAX(BURST_MAX), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .dm_addr(dm_addr), .dm_be(dm_be), .dm_din(dm_din), .dm_wr(dm_wr), .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // dm_4k stand-in: combinational read, byte-enabled write on the falling edge
    logic [31:0] mem [0:4095];
    logic        init_mem = 1'b0;

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE0000 | 32'(i);
    endfunction

    assign dm_dout = mem[dm_addr];

    always @(negedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
        end else if (dm_wr) begin
            for (int b = 0; b < 4; b++)
                if (dm_be[b]) mem[dm_addr][8*b +: 8] <= dm_din[8*b +: 8];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd);
        m0_req = req; m0_we = we; m0_be = be; m0_addr = addr; m0_wdata = wd;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                          input logic [11:0] addr, input logic [31:0] wd, input logic lock);
        m1_req = req; m1_we = we; m1_be = be; m1_addr = addr; m1_wdata = wd; m1_lock = lock;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        init_mem = 1'b1;
        drive0(1'b1, 1'b0, 4'hF, 12'h000, 32'h0);
        drive1(1'b1, 1'b0, 4'hF, 12'h001, 32'h0, 1'b0);
        @(negedge clk);
        #1;
        init_mem = 1'b0;
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din} !== 51'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_port: got gnt=%b%b wr=%b be=%h addr=%h din=%h, expected all 0",
                     m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din);
        end
        n_cmp++;
        if ({m0_rvalid, m1_rvalid, m0_rdata, m1_rdata} !== 66'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_read: got rv=%b%b rd0=%h rd1=%h, expected 0",
                     m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL first_contention: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
        end
        tick; #2;
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== 2'b01) begin
            n_fail++;
            $display("[TB] FAIL second_contention: got gnt=%b%b expected 01", m0_gnt, m1_gnt);
        end
        n_cmp++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, pat(0), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL first_read_return: got rv0=%b rd0=%h rv1=%b expected 1 %h 0",
                     m0_rvalid, m0_rdata, m1_rvalid, pat(0));
        end
        tick; #2;
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL third_contention: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
        end
        n_cmp++;
        if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, pat(1), 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL second_read_return: got rv1=%b rd1=%h rv0=%b expected 1 %h 0",
                     m1_rvalid, m1_rdata, m0_rvalid, pat(1));
        end
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        tick;
    endtask

    task automatic test_write_read;
        drive0(1'b1, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF);
        #2;
        n_cmp++;
        if ({m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din} !== {1'b1, 1'b0, 1'b1, 4'hF, 12'h010, 32'hDEADBEEF}) begin
            n_fail++;
            $display("[TB] FAIL m0_write_port: got gnt=%b%b wr=%b be=%h addr=%h din=%h expected 10 1 f 010 deadbeef",
                     m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din);
        end
        tick;
        drive0(1'b1, 1'b0, 4'hF, 12'h010, 32'h0);
        #2;
        n_cmp++;
        if ({m0_gnt, dm_wr, dm_addr, m0_rvalid} !== {1'b1, 1'b0, 12'h010, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL m0_read_port: got gnt=%b wr=%b addr=%h rv0=%b expected 1 0 010 0",
                     m0_gnt, dm_wr, dm_addr, m0_rvalid);
        end
        tick;
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        #2;
        n_cmp++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL m0_write_then_read: got rv0=%b rd0=%h rv1=%b expected 1 deadbeef 0",
                     m0_rvalid, m0_rdata, m1_rvalid);
        end
        tick;
        n_cmp++;
        if (m0_rvalid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL m0_rvalid_pulse: got %b expected 0", m0_rvalid);
        end
    endtask

    task automatic test_byte_write;
        drive1(1'b1, 1'b1, 4'hF, 12'h020, 32'h11223344, 1'b0);
        tick;
        drive1(1'b1, 1'b1, 4'b0100, 12'h020, 32'h00AA0000, 1'b0);
        #2;
        n_cmp++;
        if ({m1_gnt, dm_wr, dm_be, dm_din} !== {1'b1, 1'b1, 4'b0100, 32'h00AA0000}) begin
            n_fail++;
            $display("[TB] FAIL m1_byte_port: got gnt=%b wr=%b be=%b din=%h expected 1 1 0100 00aa0000",
                     m1_gnt, dm_wr, dm_be, dm_din);
        end
        tick;
        drive1(1'b1, 1'b0, 4'hF, 12'h020, 32'h0, 1'b0);
        tick;
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        #2;
        n_cmp++;
        if ({m1_rvalid, m1_rdata} !== {1'b1, 32'h11AA3344}) begin
            n_fail++;
            $display("[TB] FAIL m1_byte_merge: got rv1=%b rd1=%h expected 1 11aa3344", m1_rvalid, m1_rdata);
        end
        n_cmp++;
        if ({m0_rvalid, m0_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("[TB] FAIL m0_rdata_hold: got rv0=%b rd0=%h expected 0 deadbeef", m0_rvalid, m0_rdata);
        end
        tick;
    endtask

    task automatic test_burst;
        int m1_cnt;
        int cyc;
        logic exp_m1;
        drive0(1'b1, 1'b0, 4'hF, 12'h030, 32'h0);
        tick;
        drive1(1'b1, 1'b0, 4'hF, 12'h040, 32'h0, 1'b1);
        m1_cnt = 0;
        cyc = 0;
        // 8 locked beats, then one turn for m0, then m1 finishes its 12 beats
        while (m1_cnt < 12 && cyc < 30) begin
            #2;
            exp_m1 = (cyc != BURST_MAX);
            n_cmp++;
            if ({m0_gnt, m1_gnt} !== {~exp_m1, exp_m1}) begin
                n_fail++;
                $display("[TB] FAIL burst_cycle_%0d: got gnt=%b%b expected %b%b",
                         cyc, m0_gnt, m1_gnt, ~exp_m1, exp_m1);
            end
            if (m1_gnt) m1_cnt++;
            tick;
            cyc++;
            if (m1_cnt == 12) drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        end
        n_cmp++;
        if (cyc !== 13) begin
            n_fail++;
            $display("[TB] FAIL burst_length: got %0d cycles for 12 m1 beats expected 13", cyc);
        end
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        tick;
    endtask

    task automatic test_reset_mid_read;
        drive1(1'b1, 1'b0, 4'hF, 12'h050, 32'h0, 1'b0);
        #2;
        n_cmp++;
        if (m1_gnt !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL pre_reset_grant: got m1_gnt=%b expected 1", m1_gnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din} !== 51'd0) begin
            n_fail++;
            $display("[TB] FAIL mid_reset_port: got gnt=%b%b wr=%b be=%h addr=%h din=%h expected all 0",
                     m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({m1_rvalid, m1_rdata, m0_rdata} !== 65'd0) begin
            n_fail++;
            $display("[TB] FAIL rvalid_dropped: got rv1=%b rd1=%h rd0=%h expected 0 0 0",
                     m1_rvalid, m1_rdata, m0_rdata);
        end
        rst = 1'b1;
        drive0(1'b1, 1'b0, 4'hF, 12'h060, 32'h0);
        #2;
        n_cmp++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            n_fail++;
            $display("[TB] FAIL post_reset_contention: got gnt=%b%b expected 10", m0_gnt, m1_gnt);
        end
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        tick;
    endtask

    task automatic test_idle;
        tick;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++;
            if ({m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din, m0_rvalid, m1_rvalid} !== 53'd0) begin
                n_fail++;
                $display("[TB] FAIL idle_%0d: got gnt=%b%b wr=%b be=%h addr=%h din=%h rv=%b%b expected all 0",
                         i, m0_gnt, m1_gnt, dm_wr, dm_be, dm_addr, dm_din, m0_rvalid, m1_rvalid);
            end
            tick;
        end
        drive0(1'b1, 1'b0, 4'hF, 12'h010, 32'h0);
        tick;
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        #2;
        n_cmp++;
        if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("[TB] FAIL idle_mem_kept: got rv0=%b rd0=%h expected 1 deadbeef", m0_rvalid, m0_rdata);
        end
        tick;
    endtask

    // Reference model: transaction view of who gets the memory each cycle
    task automatic test_random;
        logic [31:0] ref_mem [16];
        int          prev_winner;
        int          beats;
        logic        locked;
        int          win;
        logic        ev0, ev1;
        logic [31:0] ed0, ed1;
        logic        e_wr;
        logic [3:0]  e_be;
        logic [11:0] e_addr;
        logic [31:0] e_din;
        logic [3:0]  idx;

        for (int i = 0; i < 16; i++) ref_mem[i] = pat(12'h100 + i);
        rst = 1'b0;
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        tick;
        rst = 1'b1;
        prev_winner = 1;
        beats = 0;
        locked = 1'b0;
        ev0 = 1'b0; ev1 = 1'b0; ed0 = '0; ed1 = '0;

        for (int n = 0; n < 400; n++) begin
            drive0(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 12'h100 + 12'($urandom % 16), $urandom);
            drive1(($urandom % 4) != 0, $urandom % 2, 4'($urandom), 12'h100 + 12'($urandom % 16), $urandom,
                   ($urandom % 3) != 0);
            #2;
            if (m1_req && locked)         win = 1;
            else if (m0_req && m1_req)    win = 1 - prev_winner;
            else if (m0_req)              win = 0;
            else if (m1_req)              win = 1;
            else                          win = -1;

            n_cmp++;
            if ({m0_gnt, m1_gnt} !== {win == 0, win == 1}) begin
                n_fail++;
                $display("[TB] FAIL rand_grant_%0d: got gnt=%b%b expected %b%b",
                         n, m0_gnt, m1_gnt, win == 0, win == 1);
            end

            e_wr = 1'b0; e_be = '0; e_addr = '0; e_din = '0;
            if (win == 0) begin
                e_wr = m0_we; e_be = m0_be; e_addr = m0_addr; e_din = m0_wdata;
            end else if (win == 1) begin
                e_wr = m1_we; e_be = m1_be; e_addr = m1_addr; e_din = m1_wdata;
            end
            n_cmp++;
            if ({dm_wr, dm_be, dm_addr, dm_din} !== {e_wr, e_be, e_addr, e_din}) begin
                n_fail++;
                $display("[TB] FAIL rand_port_%0d: got wr=%b be=%h addr=%h din=%h expected %b %h %h %h",
                         n, dm_wr, dm_be, dm_addr, dm_din, e_wr, e_be, e_addr, e_din);
            end

            idx = e_addr[3:0];
            ev0 = (win == 0) && !e_wr;
            ev1 = (win == 1) && !e_wr;
            if (ev0) ed0 = ref_mem[idx];
            if (ev1) ed1 = ref_mem[idx];
            if (win >= 0 && e_wr)
                for (int b = 0; b < 4; b++)
                    if (e_be[b]) ref_mem[idx][8*b +: 8] = e_din[8*b +: 8];

            if (win == 1 && m1_lock) begin
                if (beats < 15) beats++;
                locked = (beats < BURST_MAX);
            end else begin
                beats = 0;
                locked = 1'b0;
            end
            if (win >= 0) prev_winner = win;

            tick;
            n_cmp++;
            if ({m0_rvalid, m0_rdata, m1_rvalid, m1_rdata} !== {ev0, ed0, ev1, ed1}) begin
                n_fail++;
                $display("[TB] FAIL rand_read_%0d: got rv0=%b rd0=%h rv1=%b rd1=%h expected %b %h %b %h",
                         n, m0_rvalid, m0_rdata, m1_rvalid, m1_rdata, ev0, ed0, ev1, ed1);
            end
        end
        drive0(1'b0, 1'b0, 4'h0, 12'h0, 32'h0);
        drive1(1'b0, 1'b0, 4'h0, 12'h0, 32'h0, 1'b0);
        tick;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset;
        test_write_read;
        test_byte_write;
        test_burst;
        test_reset_mid_read;
        test_idle;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
